// File: rtl/i2s_tdm_tx.sv
// Generic synchronous FIFO; one-cycle write-to-level latency, combinational read of head entry.
// Backpressure: push ignored while full, pop ignored while empty.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    output logic [W-1:0]               dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push, pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign push    = push_i && !full_o;
    assign pop     = pop_i && !empty_o;

    always_comb begin
        wr_d  = push ? wr_q + AW'(1) : wr_q;
        rd_d  = pop  ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + (AW+1)'(1);
        else if (pop && !push)
            cnt_d = cnt_q - (AW+1)'(1);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem_q[wr_q] <= din_i;
    end
endmodule

// I2S / left-justified / TDM serialiser with frame FIFO; pins registered, first bit one cycle after enable.
// Backpressure: frame_ready_o low while FIFO full; an empty FIFO at a frame boundary sends zeros and flags underrun.
module i2s_tdm_tx #(
    parameter int DATA_W     = 24,
    parameter int SLOT_W     = 32,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int BCLK_HALF  = 2
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           en_i,
    input  logic [1:0]                     mode_i,
    input  logic [NUM_CH*DATA_W-1:0]       frame_i,
    input  logic                           frame_valid_i,
    output logic                           frame_ready_o,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level_o,
    output logic                           underrun_o,
    input  logic                           underrun_clr_i,
    output logic                           frame_start_o,
    output logic                           bclk_o,
    output logic                           ws_o,
    output logic                           sdata_o
);
    localparam int FRAME_BITS = NUM_CH * SLOT_W;
    localparam int HALF_BITS  = (NUM_CH / 2) * SLOT_W;
    localparam int BW         = $clog2(FRAME_BITS + 1);
    localparam int DVW        = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [1:0] MODE_I2S  = 2'd0;
    localparam logic [1:0] MODE_TDM  = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic [DVW-1:0]          div_q, div_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [1:0]              mode_q, mode_d;
    logic [FRAME_BITS-1:0]   sr_q, sr_d;
    logic                    bclk_q, bclk_d, ws_q, ws_d, sdata_q, sdata_d;
    logic                    cur_bit_q, cur_bit_d, frame_start_q, frame_start_d;
    logic                    underrun_q, underrun_d;

    logic [NUM_CH*DATA_W-1:0] fifo_dout;
    logic                     fifo_full, fifo_empty;
    logic                     div_wrap, fall, frame_end, boundary, bit_step;
    logic [FRAME_BITS-1:0]    load_frame;
    logic [1:0]               eff_mode;
    logic [BW-1:0]            next_idx;
    logic                     stream_bit;

    // Lay channels out as consecutive slots, sample MSB-first at the top of each slot.
    function automatic logic [FRAME_BITS-1:0] pack(input logic [NUM_CH*DATA_W-1:0] f);
        logic [FRAME_BITS-1:0] r;
        logic [SLOT_W-1:0]     s;
        r = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            s = '0;
            s[SLOT_W-1 -: DATA_W] = f[k*DATA_W +: DATA_W];
            r[FRAME_BITS-1-k*SLOT_W -: SLOT_W] = s;
        end
        return r;
    endfunction

    fifo #(.W(NUM_CH*DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (frame_valid_i),
        .din_i   (frame_i),
        .pop_i   (boundary),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    assign div_wrap   = (div_q == DVW'(BCLK_HALF - 1));
    assign fall       = (state_q == RUN) && div_wrap && bclk_q;
    assign frame_end  = fall && (bit_q == BW'(FRAME_BITS - 1));
    assign boundary   = en_i && ((state_q == IDLE) || frame_end);
    assign bit_step   = boundary || (fall && !frame_end);
    assign load_frame = fifo_empty ? '0 : pack(fifo_dout);

    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        bclk_d        = bclk_q;
        bit_d         = bit_q;
        mode_d        = mode_q;
        sr_d          = sr_q;
        cur_bit_d     = cur_bit_q;
        ws_d          = ws_q;
        sdata_d       = sdata_q;
        frame_start_d = 1'b0;
        underrun_d    = underrun_q & ~underrun_clr_i;
        eff_mode      = mode_q;
        next_idx      = bit_q + BW'(1);
        stream_bit    = sr_q[FRAME_BITS-1];

        if (boundary) begin
            state_d       = RUN;
            div_d         = '0;
            bclk_d        = 1'b0;
            frame_start_d = 1'b1;
            eff_mode      = (mode_i == MODE_RSVD) ? MODE_I2S : mode_i;
            mode_d        = eff_mode;
            next_idx      = '0;
            stream_bit    = load_frame[FRAME_BITS-1];
            sr_d          = load_frame << 1;
            if (fifo_empty)
                underrun_d = 1'b1;
        end else if (frame_end) begin
            state_d   = IDLE;
            div_d     = '0;
            bclk_d    = 1'b0;
            bit_d     = '0;
            sr_d      = '0;
            cur_bit_d = 1'b0;
            ws_d      = 1'b0;
            sdata_d   = 1'b0;
        end else if (state_q == RUN) begin
            if (div_wrap) begin
                div_d  = '0;
                bclk_d = ~bclk_q;
                if (bclk_q)
                    sr_d = sr_q << 1;
            end else begin
                div_d = div_q + DVW'(1);
            end
        end

        // cur_bit_q still holds the previous stream bit here, giving I2S its one-BCLK lag.
        if (bit_step) begin
            bit_d     = next_idx;
            cur_bit_d = stream_bit;
            sdata_d   = (eff_mode == MODE_I2S) ? cur_bit_q : stream_bit;
            if (eff_mode == MODE_TDM)
                ws_d = (next_idx == '0);
            else
                ws_d = (next_idx >= BW'(HALF_BITS));
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= IDLE;
            div_q         <= '0;
            bclk_q        <= 1'b0;
            bit_q         <= '0;
            mode_q        <= MODE_I2S;
            sr_q          <= '0;
            cur_bit_q     <= 1'b0;
            ws_q          <= 1'b0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            bclk_q        <= bclk_d;
            bit_q         <= bit_d;
            mode_q        <= mode_d;
            sr_q          <= sr_d;
            cur_bit_q     <= cur_bit_d;
            ws_q          <= ws_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign frame_ready_o = !fifo_full;
    assign underrun_o    = underrun_q;
    assign frame_start_o = frame_start_q;
    assign bclk_o        = bclk_q;
    assign ws_o          = ws_q;
    assign sdata_o       = sdata_q;
endmodule

// File: tb/tb_i2s_tdm_tx.sv
module tb_i2s_tdm_tx;
    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    logic         en_a, valid_a, clr_a, ready_a, ur_a, fs_a, bclk_a, ws_a, sd_a;
    logic [1:0]   mode_a;
    logic [47:0]  frame_a;
    logic [3:0]   level_a;
    logic         en8, valid8, clr8, ready8, ur8, fs8, bclk8, ws8, sd8;
    logic [1:0]   mode8;
    logic [191:0] frame8;
    logic [3:0]   level8;

    i2s_tdm_tx dut (
        .clk_i(clk), .rstn_i(rstn), .en_i(en_a), .mode_i(mode_a), .frame_i(frame_a),
        .frame_valid_i(valid_a), .frame_ready_o(ready_a), .fifo_level_o(level_a),
        .underrun_o(ur_a), .underrun_clr_i(clr_a), .frame_start_o(fs_a),
        .bclk_o(bclk_a), .ws_o(ws_a), .sdata_o(sd_a)
    );

    i2s_tdm_tx #(.NUM_CH(8)) dut8 (
        .clk_i(clk), .rstn_i(rstn), .en_i(en8), .mode_i(mode8), .frame_i(frame8),
        .frame_valid_i(valid8), .frame_ready_o(ready8), .fifo_level_o(level8),
        .underrun_o(ur8), .underrun_clr_i(clr8), .frame_start_o(fs8),
        .bclk_o(bclk8), .ws_o(ws8), .sdata_o(sd8)
    );

    logic sel = 1'b0;
    logic mon_bclk, mon_ws, mon_sd, mon_fs;
    assign mon_bclk = sel ? bclk8 : bclk_a;
    assign mon_ws   = sel ? ws8   : ws_a;
    assign mon_sd   = sel ? sd8   : sd_a;
    assign mon_fs   = sel ? fs8   : fs_a;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] exp_q[$];
    logic        cap_sd[256];
    logic        cap_ws[256];
    time         fs_time;

    function automatic logic [23:0] get_sample(input int base);
        logic [23:0] s;
        for (int b = 0; b < 24; b++) s[23-b] = cap_sd[base+b];
        return s;
    endfunction

    function automatic logic [23:0] pop_exp();
        if (exp_q.size() == 0) return 24'hxxxxxx;
        return exp_q.pop_front();
    endfunction

    task automatic write_a(input logic [23:0] l, input logic [23:0] r, input bit accept);
        @(negedge clk);
        frame_a = {r, l};
        valid_a = 1'b1;
        if (accept) begin
            exp_q.push_back(l);
            exp_q.push_back(r);
        end
        @(negedge clk);
        valid_a = 1'b0;
    endtask

    // Waits for frame_start, then records ws/sdata at each BCLK rising edge.
    task automatic capture(input int nbits, output bit ok);
        int   t;
        logic p;
        bit   got;
        ok = 1'b1;
        t = 0;
        while (mon_fs !== 1'b1 && t < 5000) begin @(negedge clk); t++; end
        if (mon_fs !== 1'b1) begin ok = 1'b0; return; end
        fs_time = $time;
        for (int i = 0; i < nbits; i++) begin
            t = 0;
            got = 1'b0;
            while (!got && t < 100) begin
                p = mon_bclk;
                @(negedge clk);
                t++;
                got = (p === 1'b0) && (mon_bclk === 1'b1);
            end
            if (!got) begin ok = 1'b0; return; end
            cap_sd[i] = mon_sd;
            cap_ws[i] = mon_ws;
        end
    endtask

    task automatic test_reset();
        en_a = 0; valid_a = 0; clr_a = 0; mode_a = 0; frame_a = '0;
        en8 = 0; valid8 = 0; clr8 = 0; mode8 = 2'd2; frame8 = '0;
        #3 rstn = 1'b0;
        #10;
        checks++; if (bclk_a !== 1'b0) begin errors++; $display("FAIL reset_bclk got %b want 0", bclk_a); end
        checks++; if (ws_a !== 1'b0) begin errors++; $display("FAIL reset_ws got %b want 0", ws_a); end
        checks++; if (sd_a !== 1'b0) begin errors++; $display("FAIL reset_sdata got %b want 0", sd_a); end
        checks++; if (fs_a !== 1'b0) begin errors++; $display("FAIL reset_fs got %b want 0", fs_a); end
        checks++; if (ur_a !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", ur_a); end
        checks++; if (level_a !== 4'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level_a); end
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready_a); end
        checks++; if (bclk8 !== 1'b0) begin errors++; $display("FAIL reset_bclk8 got %b want 0", bclk8); end
        @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_i2s();
        bit          ok;
        time         t1;
        int          bad;
        logic        pad;
        logic [23:0] e, g;
        sel = 1'b0;
        mode_a = 2'd0;
        write_a(24'hA5A5A5, 24'h5A5A5A, 1'b1);
        write_a(24'h123456, 24'hFEDCBA, 1'b1);
        checks++; if (level_a !== 4'd2) begin errors++; $display("FAIL i2s_level got %0d want 2", level_a); end
        @(negedge clk);
        en_a = 1'b1;
        t1 = 0;
        for (int f = 0; f < 2; f++) begin
            capture(64, ok);
            if (f == 1) en_a = 1'b0;
            checks++; if (!ok) begin errors++; $display("FAIL i2s_capture%0d got timeout want frame", f); end
            if (f == 1) begin
                checks++; if (fs_time - t1 !== 2560) begin errors++; $display("FAIL i2s_period got %0t want 2560", fs_time - t1); end
            end
            t1 = fs_time;
            checks++; if (cap_sd[0] !== 1'b0) begin errors++; $display("FAIL i2s_first_bit%0d got %b want 0", f, cap_sd[0]); end
            bad = 0;
            for (int i = 0; i < 64; i++) if (cap_ws[i] !== (i >= 32)) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL i2s_ws%0d got %0d wrong bits want 0", f, bad); end
            for (int k = 0; k < 2; k++) begin
                e = pop_exp();
                g = get_sample(k*32 + 1);
                checks++; if (g !== e) begin errors++; $display("FAIL i2s_sample f%0d ch%0d got %h want %h", f, k, g, e); end
                pad = 1'b0;
                for (int b = 25; b < 32; b++) pad = pad | cap_sd[k*32+b];
                checks++; if (pad !== 1'b0) begin errors++; $display("FAIL i2s_pad f%0d ch%0d got %b want 0", f, k, pad); end
            end
        end
        repeat (300) @(negedge clk);
    endtask

    task automatic test_lj();
        bit          ok;
        logic        pad;
        logic [23:0] e, g;
        sel = 1'b0;
        mode_a = 2'd1;
        write_a(24'hA5A5A5, 24'h5A5A5A, 1'b1);
        @(negedge clk);
        en_a = 1'b1;
        capture(64, ok);
        en_a = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL lj_capture got timeout want frame"); end
        checks++; if (cap_ws[0] !== 1'b0 || cap_sd[0] !== 1'b1) begin errors++; $display("FAIL lj_msb_align got ws=%b sd=%b want ws=0 sd=1", cap_ws[0], cap_sd[0]); end
        checks++; if (cap_ws[31] !== 1'b0 || cap_ws[32] !== 1'b1) begin errors++; $display("FAIL lj_ws_edge got %b%b want 01", cap_ws[31], cap_ws[32]); end
        for (int k = 0; k < 2; k++) begin
            e = pop_exp();
            g = get_sample(k*32);
            checks++; if (g !== e) begin errors++; $display("FAIL lj_sample ch%0d got %h want %h", k, g, e); end
            pad = 1'b0;
            for (int b = 24; b < 32; b++) pad = pad | cap_sd[k*32+b];
            checks++; if (pad !== 1'b0) begin errors++; $display("FAIL lj_pad ch%0d got %b want 0", k, pad); end
        end
        repeat (300) @(negedge clk);
    endtask

    task automatic test_tdm();
        bit          ok;
        int          bad;
        logic        pad;
        logic [23:0] e, g;
        sel = 1'b1;
        mode8 = 2'd2;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            frame8[k*24 +: 24] = 24'(k + 1);
            exp_q.push_back(24'(k + 1));
        end
        valid8 = 1'b1;
        @(negedge clk);
        valid8 = 1'b0;
        en8 = 1'b1;
        capture(256, ok);
        en8 = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL tdm_capture got timeout want frame"); end
        checks++; if (cap_ws[0] !== 1'b1) begin errors++; $display("FAIL tdm_ws_pulse got %b want 1", cap_ws[0]); end
        bad = 0;
        for (int i = 1; i < 256; i++) if (cap_ws[i] !== 1'b0) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL tdm_ws_rest got %0d high bits want 0", bad); end
        for (int k = 0; k < 8; k++) begin
            e = pop_exp();
            g = get_sample(k*32);
            pad = 1'b0;
            for (int b = 24; b < 32; b++) pad = pad | cap_sd[k*32+b];
            checks++; if (g !== e || pad !== 1'b0) begin errors++; $display("FAIL tdm_slot%0d got %h pad %b want %h pad 0", k, g, pad, e); end
        end
        repeat (20) @(negedge clk);
        sel = 1'b0;
    endtask

    task automatic test_disable();
        bit          ok;
        int          t, nfs, nhi;
        logic [23:0] e, g;
        sel = 1'b0;
        mode_a = 2'd1;
        write_a(24'h0F0F0F, 24'hF0F0F0, 1'b1);
        @(negedge clk);
        en_a = 1'b1;
        fork
            capture(64, ok);
            begin
                t = 0;
                while (fs_a !== 1'b1 && t < 5000) begin @(negedge clk); t++; end
                repeat (128) @(negedge clk);
                en_a = 1'b0;
            end
        join
        checks++; if (!ok) begin errors++; $display("FAIL dis_capture got timeout want full frame"); end
        for (int k = 0; k < 2; k++) begin
            e = pop_exp();
            g = get_sample(k*32);
            checks++; if (g !== e) begin errors++; $display("FAIL dis_sample ch%0d got %h want %h", k, g, e); end
        end
        repeat (5) @(negedge clk);
        nfs = 0; nhi = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (fs_a !== 1'b0) nfs++;
            if (bclk_a !== 1'b0 || ws_a !== 1'b0 || sd_a !== 1'b0) nhi++;
        end
        checks++; if (nfs != 0) begin errors++; $display("FAIL dis_idle_fs got %0d pulses want 0", nfs); end
        checks++; if (nhi != 0) begin errors++; $display("FAIL dis_idle_pins got %0d active cycles want 0", nhi); end
    endtask

    task automatic test_fifo();
        bit          ok;
        logic [23:0] e, g;
        sel = 1'b0;
        mode_a = 2'd1;
        for (int i = 0; i < 8; i++) write_a(24'h100000 + 24'(i), 24'h200000 + 24'(i), 1'b1);
        checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL fifo_full_ready got %b want 0", ready_a); end
        checks++; if (level_a !== 4'd8) begin errors++; $display("FAIL fifo_full_level got %0d want 8", level_a); end
        write_a(24'hDEAD00, 24'hBEEF00, 1'b0);
        checks++; if (level_a !== 4'd8) begin errors++; $display("FAIL fifo_ninth_write got %0d want 8", level_a); end
        @(negedge clk);
        en_a = 1'b1;
        for (int f = 0; f < 8; f++) begin
            capture(64, ok);
            if (f == 7) en_a = 1'b0;
            checks++; if (!ok) begin errors++; $display("FAIL fifo_capture%0d got timeout want frame", f); end
            checks++; if (level_a !== 4'(7 - f)) begin errors++; $display("FAIL fifo_level%0d got %0d want %0d", f, level_a, 7 - f); end
            for (int k = 0; k < 2; k++) begin
                e = pop_exp();
                g = get_sample(k*32);
                checks++; if (g !== e) begin errors++; $display("FAIL fifo_sample f%0d ch%0d got %h want %h", f, k, g, e); end
            end
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_underrun();
        bit          ok;
        int          t;
        logic [23:0] e, g;
        sel = 1'b0;
        mode_a = 2'd1;
        checks++; if (ur_a !== 1'b0) begin errors++; $display("FAIL ur_initial got %b want 0", ur_a); end
        exp_q.push_back(24'h0);
        exp_q.push_back(24'h0);
        @(negedge clk);
        en_a = 1'b1;
        capture(64, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ur_capture got timeout want frame"); end
        for (int k = 0; k < 2; k++) begin
            e = pop_exp();
            g = get_sample(k*32);
            checks++; if (g !== e) begin errors++; $display("FAIL ur_sample ch%0d got %h want %h", k, g, e); end
        end
        checks++; if (ur_a !== 1'b1) begin errors++; $display("FAIL ur_set got %b want 1", ur_a); end
        clr_a = 1'b1;
        @(negedge clk);
        checks++; if (ur_a !== 1'b0) begin errors++; $display("FAIL ur_clear got %b want 0", ur_a); end
        t = 0;
        while (fs_a !== 1'b1 && t < 5000) begin @(negedge clk); t++; end
        checks++; if (fs_a !== 1'b1 || ur_a !== 1'b1) begin errors++; $display("FAIL ur_set_wins got fs=%b ur=%b want 1 1", fs_a, ur_a); end
        clr_a = 1'b0;
        en_a = 1'b0;
        repeat (300) @(negedge clk);
        checks++; if (ur_a !== 1'b1) begin errors++; $display("FAIL ur_sticky got %b want 1", ur_a); end
    endtask

    task automatic test_reset_midframe();
        int t;
        sel = 1'b0;
        mode_a = 2'd0;
        write_a(24'hFFFFFF, 24'hFFFFFF, 1'b0);
        write_a(24'hFFFFFF, 24'hFFFFFF, 1'b0);
        @(negedge clk);
        en_a = 1'b1;
        t = 0;
        while (fs_a !== 1'b1 && t < 5000) begin @(negedge clk); t++; end
        repeat (150) @(negedge clk);
        t = 0;
        while (bclk_a !== 1'b1 && t < 10) begin @(negedge clk); t++; end
        checks++; if (bclk_a !== 1'b1 || ws_a !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got bclk=%b ws=%b want 1 1", bclk_a, ws_a); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (bclk_a !== 1'b0) begin errors++; $display("FAIL rst_mid_bclk got %b want 0", bclk_a); end
        checks++; if (ws_a !== 1'b0) begin errors++; $display("FAIL rst_mid_ws got %b want 0", ws_a); end
        checks++; if (sd_a !== 1'b0) begin errors++; $display("FAIL rst_mid_sdata got %b want 0", sd_a); end
        checks++; if (fs_a !== 1'b0) begin errors++; $display("FAIL rst_mid_fs got %b want 0", fs_a); end
        checks++; if (ur_a !== 1'b0) begin errors++; $display("FAIL rst_mid_underrun got %b want 0", ur_a); end
        checks++; if (level_a !== 4'd0) begin errors++; $display("FAIL rst_mid_level got %0d want 0", level_a); end
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", ready_a); end
        @(negedge clk);
        en_a = 1'b0;
        rstn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_i2s();
        test_lj();
        test_tdm();
        test_disable();
        test_fifo();
        test_underrun();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
